// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and pointer helper for the FIFO read-side stream adapter
// Contents: FIFO_DATA_W (default word width), RDAD_BUF_DEPTH (prefetch entries),
//           RDAD_BEAT_W (packet beat counter width), rdad_ptr_t and rdad_ptr_inc().
package fifo_pkg;

    localparam int FIFO_DATA_W    = 32;
    localparam int RDAD_BUF_DEPTH = 3;
    localparam int RDAD_BEAT_W    = 16;

    // Two bits cover both the 0..2 ring pointers and the 0..3 occupancy.
    typedef logic [1:0] rdad_ptr_t;

    // Ring pointer advance, wrapping at RDAD_BUF_DEPTH.
    function automatic rdad_ptr_t rdad_ptr_inc(input rdad_ptr_t p);
        return (p == rdad_ptr_t'(RDAD_BUF_DEPTH - 1)) ? '0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/rdad_prefetch_buf.sv
// rtl/rdad_prefetch_buf.sv - 3-entry circular prefetch buffer with push/pop ports
// Ports: i_clk, i_rst (sync, active-high)
//        i_push, i_push_data  write a word at tail
//        i_pop                 retire the word at head
//        o_occ                 entries held (0..3)
//        o_head_data           word at head
module rdad_prefetch_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output rdad_ptr_t         o_occ,
    output logic [DATA_W-1:0] o_head_data
);

    logic [DATA_W-1:0] r_mem [RDAD_BUF_DEPTH];
    rdad_ptr_t         r_head;
    rdad_ptr_t         r_tail;
    rdad_ptr_t         r_occ;

    // Storage is cleared on reset so the head word reads as zero afterwards.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < RDAD_BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_push_data;
                r_tail        <= rdad_ptr_inc(r_tail);
            end
            if (i_pop) begin
                r_head <= rdad_ptr_inc(r_head);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ       = r_occ;
    assign o_head_data = r_mem[r_head];

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// rtl/fifo_rd_stream_adapter.sv - async FIFO read side to valid/ready stream with packet-end tagging
// Optional feature macro: RDAD_WORDCNT_EN (adds o_word_cnt and its counter)
// Ports: i_clk, i_rst (sync, active-high)
//        i_fifo_empty, o_fifo_rd, i_fifo_rdata  FIFO read side (data one cycle after the strobe)
//        o_valid, i_ready, o_data, o_last       output stream
//        o_word_cnt                              accepted-word count (RDAD_WORDCNT_EN only)
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int DATA_W  = FIFO_DATA_W,
    parameter int PKT_LEN = 8
`ifdef RDAD_WORDCNT_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_fifo_empty,
    output logic              o_fifo_rd,
    input  logic [DATA_W-1:0] i_fifo_rdata,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
`ifdef RDAD_WORDCNT_EN
    output logic [CNT_W-1:0]  o_word_cnt,
`endif
    output logic              o_last
);

    rdad_ptr_t              w_occ;
    logic [2:0]             w_level;
    logic                   w_rd;
    logic                   w_pop;
    logic                   r_inflight;
    logic [RDAD_BEAT_W-1:0] r_beat_cnt;

    // Words already buffered plus the one arriving next cycle; reads stop
    // when these would fill the buffer, so no path from i_ready reaches o_fifo_rd.
    assign w_level   = {1'b0, w_occ} + {2'b00, r_inflight};
    assign w_rd      = !i_rst && !i_fifo_empty && (w_level < 3'(RDAD_BUF_DEPTH));
    assign o_fifo_rd = w_rd;

    assign o_valid = (w_occ != '0);
    assign w_pop   = o_valid && i_ready;
    assign o_last  = o_valid && (r_beat_cnt == RDAD_BEAT_W'(PKT_LEN - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inflight <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_inflight <= w_rd;
            if (w_pop) begin
                r_beat_cnt <= o_last ? '0 : r_beat_cnt + 1'b1;
            end
        end
    end

    // FIFO read data is valid exactly when the previous cycle issued a read.
    rdad_prefetch_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (r_inflight),
        .i_push_data (i_fifo_rdata),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_head_data (o_data)
    );

`ifdef RDAD_WORDCNT_EN
    logic [CNT_W-1:0] r_word_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word_cnt <= '0;
        end else if (w_pop) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
    end

    assign o_word_cnt = r_word_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb/tb_fifo_rd_stream_adapter.sv - directed self-checking bench for fifo_rd_stream_adapter
module tb_fifo_rd_stream_adapter;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_fifo_empty;
    logic        o_fifo_rd;
    logic [31:0] i_fifo_rdata;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic        o_last;
`ifdef RDAD_WORDCNT_EN
    logic [31:0] o_word_cnt;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream_adapter #(
        .DATA_W  (32),
        .PKT_LEN (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd    (o_fifo_rd),
        .i_fifo_rdata (i_fifo_rdata),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
`ifdef RDAD_WORDCNT_EN
        .o_word_cnt   (o_word_cnt),
`endif
        .o_last       (o_last)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          rd_cnt = 0;
    int          hold   = 0;
    int          n;
    logic [31:0] fifo_q [$];
    logic [31:0] got_d  [$];
    logic        got_l  [$];
    int          got_c  [$];
    logic        obs_rd, obs_valid, obs_last;
    logic [31:0] obs_data;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at negedge, then model the FIFO (1-cycle read latency) after posedge.
    task automatic tick();
        @(negedge clk);
        obs_rd    = o_fifo_rd;
        obs_valid = o_valid;
        obs_data  = o_data;
        obs_last  = o_last;
        chk("rd_while_empty", 64'(obs_rd && i_fifo_empty), 64'd0);
        if (prev_stall && !i_rst) begin
            chk("stall_valid", 64'(obs_valid), 64'd1);
            chk("stall_data", 64'(obs_data), 64'(prev_data));
            chk("stall_last", 64'(obs_last), 64'(prev_last));
        end
        prev_stall = obs_valid && !i_ready && !i_rst;
        prev_data  = obs_data;
        prev_last  = obs_last;
        if (obs_valid && i_ready && !i_rst) begin
            got_d.push_back(obs_data);
            got_l.push_back(obs_last);
            got_c.push_back(cyc);
        end
        if (obs_rd) rd_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (obs_rd) begin
            if (fifo_q.size() > 0) i_fifo_rdata = fifo_q.pop_front();
            else                   i_fifo_rdata = 'x;
        end
        i_fifo_empty = (fifo_q.size() == 0) || (hold > 0);
        if (hold > 0) hold--;
    endtask

    task automatic clear_obs();
        got_d.delete();
        got_l.delete();
        got_c.delete();
        rd_cnt = 0;
    endtask

    task automatic do_reset(input int cycles);
        i_rst = 1'b1;
        fifo_q.delete();
        hold = 0;
        i_fifo_empty = 1'b1;
        repeat (cycles) tick();
        i_rst = 1'b0;
    endtask

    initial begin
        i_rst        = 1'b1;
        i_fifo_empty = 1'b0;
        i_fifo_rdata = '0;
        i_ready      = 1'b0;
        fifo_q.push_back(32'hDEAD);

        // T1: reset with a non-empty FIFO
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("t1_rd", 64'(obs_rd), 64'd0);
            chk("t1_valid", 64'(obs_valid), 64'd0);
            chk("t1_last", 64'(obs_last), 64'd0);
            chk("t1_data", 64'(obs_data), 64'd0);
        end

        // T2: full-rate stream of 1..20; empty flag held 3 cycles after release
        fifo_q.delete();
        for (int i = 1; i <= 20; i++) fifo_q.push_back(32'(i));
        i_fifo_empty = 1'b1;
        hold = 2;
        i_ready = 1'b1;
        clear_obs();
        i_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2_no_early_rd", 64'(obs_rd), 64'd0);
        end
        tick();
        chk("t2_first_rd", 64'(obs_rd), 64'd1);
        tick();
        chk("t2_valid_lat1", 64'(obs_valid), 64'd0);
        tick();
        chk("t2_valid_lat2", 64'(obs_valid), 64'd1);
        chk("t2_first_data", 64'(obs_data), 64'd1);
        n = 0;
        while (got_d.size() < 20 && n < 60) begin
            tick();
            n++;
        end
        chk("t2_count", 64'(got_d.size()), 64'd20);
        for (int i = 0; i < got_d.size(); i++) begin
            chk("t2_data", 64'(got_d[i]), 64'(i + 1));
            chk("t2_last", 64'(got_l[i]), 64'((i % 8) == 7));
            chk("t2_gapless", 64'(got_c[i] - got_c[0]), 64'(i));
        end

        // T3: backpressure then release
        do_reset(2);
        for (int i = 1; i <= 10; i++) fifo_q.push_back(32'(i));
        i_fifo_empty = 1'b0;
        i_ready = 1'b0;
        clear_obs();
        repeat (10) tick();
        chk("t3_reads", 64'(rd_cnt), 64'd3);
        chk("t3_valid_held", 64'(obs_valid), 64'd1);
        chk("t3_data_held", 64'(obs_data), 64'd1);
        i_ready = 1'b1;
        n = 0;
        while (got_d.size() < 10 && n < 40) begin
            tick();
            n++;
        end
        chk("t3_count", 64'(got_d.size()), 64'd10);
        for (int i = 0; i < got_d.size(); i++) begin
            chk("t3_data", 64'(got_d[i]), 64'(i + 1));
            chk("t3_gapless", 64'(got_c[i] - got_c[0]), 64'(i));
        end

        // T4: alternating ready over 30 words
        do_reset(2);
        for (int i = 1; i <= 30; i++) fifo_q.push_back(32'(i));
        i_fifo_empty = 1'b0;
        clear_obs();
        n = 0;
        while (got_d.size() < 30 && n < 200) begin
            i_ready = (n % 2) == 0;
            tick();
            n++;
        end
        chk("t4_count", 64'(got_d.size()), 64'd30);
        for (int i = 0; i < got_d.size(); i++) begin
            chk("t4_data", 64'(got_d[i]), 64'(i + 1));
            chk("t4_last", 64'(got_l[i]), 64'((i % 8) == 7));
        end

        // T5: single word, then FIFO empty
        do_reset(2);
        fifo_q.push_back(32'hA5);
        i_fifo_empty = 1'b0;
        i_ready = 1'b1;
        clear_obs();
        repeat (8) tick();
        chk("t5_reads", 64'(rd_cnt), 64'd1);
        chk("t5_count", 64'(got_d.size()), 64'd1);
        if (got_d.size() > 0) chk("t5_data", 64'(got_d[0]), 64'hA5);
        chk("t5_valid_drop", 64'(obs_valid), 64'd0);

        // T6: reset with two buffered words and one in flight (beat count is 1 here)
        for (int i = 100; i <= 109; i++) fifo_q.push_back(32'(i));
        i_fifo_empty = 1'b0;
        i_ready = 1'b0;
        clear_obs();
        repeat (3) tick();
        chk("t6_pre_valid", 64'(obs_valid), 64'd1);
        chk("t6_pre_data", 64'(obs_data), 64'd100);
        i_rst = 1'b1;
        fifo_q.delete();
        tick();
        i_rst = 1'b0;
        tick();
        chk("t6_valid_cleared", 64'(obs_valid), 64'd0);
        for (int i = 50; i <= 52; i++) fifo_q.push_back(32'(i));
        i_fifo_empty = 1'b0;
        i_ready = 1'b1;
        clear_obs();
        repeat (8) tick();
        chk("t6_count", 64'(got_d.size()), 64'd3);
        for (int i = 0; i < got_d.size(); i++) begin
            chk("t6_data", 64'(got_d[i]), 64'(50 + i));
            chk("t6_last", 64'(got_l[i]), 64'd0);
        end
`ifdef RDAD_WORDCNT_EN
        chk("t6_word_cnt", 64'(o_word_cnt), 64'd3);
`endif
        for (int i = 53; i <= 57; i++) fifo_q.push_back(32'(i));
        i_fifo_empty = 1'b0;
        n = 0;
        while (got_d.size() < 8 && n < 30) begin
            tick();
            n++;
        end
        chk("t6_count8", 64'(got_d.size()), 64'd8);
        if (got_d.size() == 8) begin
            chk("t6_last_word", 64'(got_d[7]), 64'd57);
            chk("t6_last_on_8th", 64'(got_l[7]), 64'd1);
            chk("t6_no_last_7th", 64'(got_l[6]), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
